deinterleave_core: RTL and testbench

Receive-side Forney convolutional deinterleaver for the 204-byte packet stream produced by `interleave_top`. Parameters are I=12 branches and M=17 bytes per delay cell. Each cycle it takes one byte and reverses the interleaver's per-branch delays: branch j delays by (11−j)·M cells. It restores the original byte order with a fixed end-to-end delay and regenerates the packet sync marker. It sits directly downstream of `interleave_top`, in loopback benches and in the receive chain.

---
 rtl/interleave_pkg.sv | 30 +++
 rtl/deint_ram.sv | 33 +++
 rtl/deinterleave_core.sv | 162 ++++++++++++++++
 tb/tb_deinterleave_core.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/interleave_pkg.sv
// Shared constants and types for the Forney interleaver/deinterleaver pair.
//   NUM_BR      : commutator positions (branches)
//   CELL_M      : bytes per delay cell
//   PKT_LEN     : packet length in bytes (NUM_BR * CELL_M)
//   TOTAL_DELAY : bytes accepted before the deinterleaver output is trustworthy
//   MEM_DEPTH   : words needed to hold every branch FIFO back to back
//   branch_base : first memory word of branch j's FIFO
//   state_t     : lock state of the deinterleaver
package interleave_pkg;

    localparam int NUM_BR      = 12;
    localparam int CELL_M      = 17;
    localparam int PKT_LEN     = NUM_BR * CELL_M;
    localparam int TOTAL_DELAY = (NUM_BR - 1) * PKT_LEN;
    localparam int MEM_DEPTH   = CELL_M * NUM_BR * (NUM_BR - 1) / 2;

    typedef enum logic [1:0] {
        UNLOCKED,
        PRIMING,
        LOCKED
    } state_t;

    // Branch i holds (n_br-1-i)*m words, so the base of branch j is
    // m * sum_{i<j}(n_br-1-i) = m * (j*(n_br-1) - j*(j-1)/2).
    function automatic int branch_base(input int j, input int n_br = NUM_BR,
                                       input int m = CELL_M);
        return m * (j * (n_br - 1) - (j * (j - 1)) / 2);
    endfunction

endpackage

// File: rtl/deint_ram.sv
// Simple dual-port RAM holding all deinterleaver branch FIFOs.
// Read is combinational, so a read and a write to the same address in one
// cycle return the old contents (read-first); the caller registers the data.
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write word ({sync flag, data})
//   raddr : read address
//   rdata : read word (old contents of raddr)
module deint_ram #(
    parameter int DEPTH = 1122,
    parameter int AW    = 11,
    parameter int WW    = 9
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [WW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [WW-1:0] rdata
);

    logic [WW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/deinterleave_core.sv
// Forney convolutional deinterleaver (receive side of interleave_top).
// Branch j delays by (I-1-j)*M cells; all branch FIFOs share one RAM.
// End-to-end delay is 1 + (I-1)*I*M cycles for every byte.
//   clk        : byte clock, one byte per cycle
//   rst_n      : asynchronous active-low reset
//   din        : interleaved byte
//   syn_in     : marks the first byte of a packet
//   dout       : deinterleaved byte (0 while not valid)
//   syn_out    : restored sync marker, only with dout_valid
//   dout_valid : delay lines primed and output trustworthy
//   resync     : one-cycle pulse when syn_in arrives off branch 0
module deinterleave_core
    import interleave_pkg::*;
#(
    parameter int I  = NUM_BR,
    parameter int M  = CELL_M,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] din,
    input  logic          syn_in,
    output logic [DW-1:0] dout,
    output logic          syn_out,
    output logic          dout_valid,
    output logic          resync
);

    localparam int MEM_D      = M * I * (I - 1) / 2;
    localparam int ADDR_W     = $clog2(MEM_D);
    localparam int PTR_W      = $clog2((I - 1) * M);
    localparam int BR_W       = $clog2(I);
    localparam int CNT_W      = $clog2((I - 1) * I * M);
    localparam int LAST_PRIME = (I - 1) * I * M - 1;

    state_t                    state_reg;
    logic [BR_W-1:0]           br_reg;
    logic [CNT_W-1:0]          prime_cnt_reg;
    logic [DW-1:0]             dout_reg;
    logic                      syn_out_reg;
    logic                      dout_valid_reg;
    logic                      resync_reg;

    logic                      accept;
    logic [BR_W-1:0]           br_cur;
    logic                      is_bypass;
    logic                      resync_hit;
    logic                      valid_next;
    logic [I-2:0][ADDR_W-1:0]  branch_addr;
    logic [ADDR_W-1:0]         rd_addr;
    logic [DW:0]               ram_rdata;
    logic [DW:0]               rd_word;

    // Before the first sync nothing is accepted; afterwards every byte is.
    assign accept     = (state_reg != UNLOCKED) || syn_in;
    // A sync byte always lands on branch 0, whatever the commutator expected.
    assign br_cur     = syn_in ? '0 : br_reg;
    assign is_bypass  = (br_cur == BR_W'(I - 1));
    assign resync_hit = syn_in && (state_reg != UNLOCKED) && (br_reg != '0);
    // The resyncing byte itself is already untrusted, so its read is masked.
    assign valid_next = (state_reg == LOCKED) && !resync_hit;

    // One circular pointer per delayed branch; the last branch is a bypass.
    generate
        for (genvar gi = 0; gi < I - 1; gi++) begin : g_branch
            localparam int                LEN  = (I - 1 - gi) * M;
            localparam logic [ADDR_W-1:0] BASE = ADDR_W'(branch_base(gi, I, M));

            logic [PTR_W-1:0] ptr_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ptr_reg <= '0;
                end else if (accept && (br_cur == BR_W'(gi))) begin
                    ptr_reg <= (ptr_reg == PTR_W'(LEN - 1)) ? '0 : ptr_reg + PTR_W'(1);
                end
            end

            assign branch_addr[gi] = BASE + ADDR_W'(ptr_reg);
        end
    endgenerate

    always_comb begin
        rd_addr = '0;
        for (int k = 0; k < I - 1; k++) begin
            if (br_cur == BR_W'(k)) begin
                rd_addr = branch_addr[k];
            end
        end
    end

    // Same address read and written: the old word leaves as the new one enters.
    deint_ram #(
        .DEPTH (MEM_D),
        .AW    (ADDR_W),
        .WW    (DW + 1)
    ) u_ram (
        .clk   (clk),
        .we    (accept && !is_bypass),
        .waddr (rd_addr),
        .wdata ({syn_in, din}),
        .raddr (rd_addr),
        .rdata (ram_rdata)
    );

    assign rd_word = is_bypass ? {syn_in, din} : ram_rdata;

    // Commutator, prime counter, lock FSM and output register.
    // prime_cnt_reg holds the index of the next byte, the sync byte being 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= UNLOCKED;
            br_reg         <= '0;
            prime_cnt_reg  <= '0;
            dout_reg       <= '0;
            syn_out_reg    <= 1'b0;
            dout_valid_reg <= 1'b0;
            resync_reg     <= 1'b0;
        end else begin
            resync_reg     <= resync_hit;
            dout_valid_reg <= valid_next;
            dout_reg       <= valid_next ? rd_word[DW-1:0] : '0;
            syn_out_reg    <= valid_next && rd_word[DW];

            if (accept) begin
                br_reg <= is_bypass ? '0 : br_cur + BR_W'(1);
            end

            case (state_reg)
                UNLOCKED: begin
                    if (syn_in) begin
                        state_reg     <= PRIMING;
                        prime_cnt_reg <= CNT_W'(1);
                    end
                end
                PRIMING: begin
                    if (resync_hit) begin
                        prime_cnt_reg <= CNT_W'(1);
                    end else begin
                        if (prime_cnt_reg == CNT_W'(LAST_PRIME)) begin
                            state_reg <= LOCKED;
                        end
                        prime_cnt_reg <= prime_cnt_reg + CNT_W'(1);
                    end
                end
                LOCKED: begin
                    if (resync_hit) begin
                        state_reg     <= PRIMING;
                        prime_cnt_reg <= CNT_W'(1);
                    end
                end
                default: state_reg <= UNLOCKED;
            endcase
        end
    end

    assign dout       = dout_reg;
    assign syn_out    = syn_out_reg;
    assign dout_valid = dout_valid_reg;
    assign resync     = resync_reg;

endmodule

// File: tb/tb_deinterleave_core.sv
// Scoreboard bench for deinterleave_core.
// Stimulus drives counting segments (din = i mod 204, sync on 0). For such a
// stream the byte visible at cycle c is the byte issued at c - 2245 for every
// branch, so each issued byte whose output falls inside a valid window pushes
// {output cycle, data, sync} into a queue. The monitor checks every cycle:
// dout_valid must be high exactly when the queue head matches the cycle.
module tb_deinterleave_core;
    import interleave_pkg::*;

    localparam int LAT = TOTAL_DELAY + 1;
    localparam int LA  = 12 * 230 + 5;   // next byte would be on branch 5
    localparam int LB  = LAT + 400;
    localparam int LC  = LAT + 250;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din = '0;
    logic       syn_in = 1'b0;
    logic [7:0] dout;
    logic       syn_out;
    logic       dout_valid;
    logic       resync;

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic       syn;
    } exp_t;

    exp_t exp_q[$];
    int   rs_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b1;

    deinterleave_core #(.I(12), .M(17), .DW(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .syn_in     (syn_in),
        .dout       (dout),
        .syn_out    (syn_out),
        .dout_valid (dout_valid),
        .resync     (resync)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, req);
        end
    endtask

    // Monitor: one scoreboard step per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        bit   exp_v;
        bit   exp_rs;
        exp_t e;
        if (mon_en) begin
            exp_v = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
            chk("dout_valid", int'(dout_valid), int'(exp_v));
            if (exp_v) begin
                e = exp_q.pop_front();
                chk("dout", int'(dout), int'(e.data));
                chk("syn_out", int'(syn_out), int'(e.syn));
            end else begin
                chk("idle_zero", int'({syn_out, dout}), 0);
            end
            exp_rs = (rs_q.size() > 0) && (rs_q[0] == cyc);
            chk("resync", int'(resync), int'(exp_rs));
            if (exp_rs) begin
                void'(rs_q.pop_front());
            end
        end
    end

    task automatic drive(input logic [7:0] d, input logic s);
        @(posedge clk);
        #1;
        din    = d;
        syn_in = s;
    endtask

    // Counting segment of len bytes starting with a sync byte. Outputs of
    // bytes i with i + LAT <= last_valid (relative to segment start) are
    // expected; later ones are cut off by a resync or reset.
    task automatic seg(input int len, input int last_valid, input bit is_resync);
        exp_t e;
        for (int i = 0; i < len; i++) begin
            drive(8'(i % PKT_LEN), (i % PKT_LEN) == 0);
            if (i + LAT <= last_valid) begin
                e.cyc  = cyc + LAT;
                e.data = 8'(i % PKT_LEN);
                e.syn  = ((i % PKT_LEN) == 0);
                exp_q.push_back(e);
            end
            if (i == 0 && is_resync) begin
                rs_q.push_back(cyc + 1);
            end
        end
    endtask

    initial begin
        // Held in reset, then idle without sync: nothing may become valid.
        repeat (4) drive(8'hA5, 1'b0);
        rst_n = 1'b1;
        for (int n = 0; n < 500; n++) begin
            drive(8'($urandom_range(0, 255)), 1'b0);
        end

        // Lock on the first sync; then resync on branch 5 while locked.
        seg(LA, LA, 1'b0);
        seg(LB, LB - 1, 1'b1);

        // Asynchronous reset while locked: outputs clear within the cycle.
        @(posedge clk);
        #1;
        rst_n  = 1'b0;
        din    = '0;
        syn_in = 1'b0;
        #1;
        chk("async_rst", int'({resync, dout_valid, syn_out, dout}), 0);
        repeat (3) drive(8'h00, 1'b0);
        rst_n = 1'b1;
        for (int n = 0; n < 20; n++) begin
            drive(8'($urandom_range(0, 255)), 1'b0);
        end

        // Priming restarts from the next sync after reset.
        seg(LC, LC - 1, 1'b0);

        @(posedge clk);
        #1;
        mon_en = 1'b0;
        chk("exp_q_drained", exp_q.size(), 0);
        chk("rs_q_drained", rs_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
